axis_packet_fifo: RTL and testbench

Synchronous AXI4-Stream FIFO that buffers the output of the USB3 stream width converter before the next consumer. It is byte-oriented and carries tdata/tstrb/tkeep/tlast/tid/tdest/tuser for every beat. In normal mode it is a plain elastic buffer. In packet mode (store-and-forward) it releases a frame only after that frame's tlast has been stored, and it drops any frame that can never fit in the buffer.

---
 rtl/axis_packet_fifo_pkg.sv | 17 +
 rtl/axis_fifo_ram.sv | 27 ++
 rtl/axis_packet_fifo.sv | 196 +++++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
// Holds the packet-mode state encoding and the pointer-width helper.
package axis_packet_fifo_pkg;

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_DROP = 1'b1
   } fifo_state_t;

   localparam int DROP_CNT_W = 16;

   // Pointers carry one extra wrap bit beyond the address.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with a registered read port.
// Ports: aclk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr/rd_data read port.
module axis_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     aclk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO, cut-through or store-and-forward with oversize drop.
// Ports: aclk/areset; s_axis_* in; m_axis_* out; status_count/drop/drop_cnt.
module axis_packet_fifo
   import axis_packet_fifo_pkg::*;
#(
   parameter int TDATA_WIDTH          = 4,
   parameter int TID_WIDTH            = 1,
   parameter int TDEST_WIDTH          = 1,
   parameter int TUSER_WIDTH_PER_BYTE = 1,
   parameter int DEPTH                = 16,
   parameter int PACKET_MODE          = 0
) (
   input  logic                                        aclk,
   input  logic                                        areset,
   input  logic                                        s_axis_tvalid,
   output logic                                        s_axis_tready,
   input  logic [TDATA_WIDTH*8-1:0]                    s_axis_tdata,
   input  logic [TDATA_WIDTH-1:0]                      s_axis_tstrb,
   input  logic [TDATA_WIDTH-1:0]                      s_axis_tkeep,
   input  logic                                        s_axis_tlast,
   input  logic [TID_WIDTH-1:0]                        s_axis_tid,
   input  logic [TDEST_WIDTH-1:0]                      s_axis_tdest,
   input  logic [TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] s_axis_tuser,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic [TDATA_WIDTH*8-1:0]                    m_axis_tdata,
   output logic [TDATA_WIDTH-1:0]                      m_axis_tstrb,
   output logic [TDATA_WIDTH-1:0]                      m_axis_tkeep,
   output logic                                        m_axis_tlast,
   output logic [TID_WIDTH-1:0]                        m_axis_tid,
   output logic [TDEST_WIDTH-1:0]                      m_axis_tdest,
   output logic [TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] m_axis_tuser,
   output logic [$clog2(DEPTH):0]                      status_count,
   output logic                                        status_drop,
   output logic [DROP_CNT_W-1:0]                       status_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int DW = TDATA_WIDTH * 8;
   localparam int SW = TDATA_WIDTH;
   localparam int UW = TDATA_WIDTH * TUSER_WIDTH_PER_BYTE;
   localparam int WW = DW + 2 * SW + 1 + TID_WIDTH + TDEST_WIDTH + UW;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr;
   logic [PW-1:0] count, pkt_len;
   fifo_state_t   state, state_nxt;
   logic          s_hs, m_hs;
   logic          wr_en, rd_en, drop_now, commit_now;
   logic          readable, out_load;
   logic          ram_vld, out_vld;
   logic [WW-1:0] s_word, ram_q, out_q;
   logic          drop_q;
   logic [DROP_CNT_W-1:0] drop_cnt;

   assign s_word = {s_axis_tuser, s_axis_tdest, s_axis_tid,
                    s_axis_tlast, s_axis_tkeep, s_axis_tstrb,
                    s_axis_tdata};

   // Ready depends only on registered state.  In packet mode a frame
   // that has filled the buffer must keep flowing so it can be dropped.
   always_comb begin
      s_axis_tready = (count != FULL);
      if (PACKET_MODE != 0) begin
         s_axis_tready = (count != FULL) || (state == ST_DROP) ||
                         (pkt_len == FULL);
      end
   end

   assign s_hs = s_axis_tvalid && s_axis_tready;
   assign m_hs = out_vld && m_axis_tready;

   always_comb begin
      state_nxt  = state;
      wr_en      = 1'b0;
      drop_now   = 1'b0;
      commit_now = 1'b0;
      if (PACKET_MODE == 0) begin
         wr_en = s_hs;
      end else begin
         unique case (state)
            ST_PASS: begin
               if (s_hs) begin
                  if (pkt_len == FULL) begin
                     drop_now = 1'b1;
                     if (!s_axis_tlast) begin
                        state_nxt = ST_DROP;
                     end
                  end else begin
                     wr_en      = 1'b1;
                     commit_now = s_axis_tlast;
                  end
               end
            end
            ST_DROP: begin
               if (s_hs && s_axis_tlast) begin
                  state_nxt = ST_PASS;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= ST_PASS;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         pkt_len    <= '0;
         count      <= '0;
         drop_q     <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (drop_now) begin
            wr_ptr <= commit_ptr;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end

         if (PACKET_MODE == 0) begin
            commit_ptr <= wr_ptr + PW'(wr_en);
         end else if (commit_now) begin
            commit_ptr <= wr_ptr + PW'(1);
         end

         if (PACKET_MODE == 0 || drop_now || commit_now) begin
            pkt_len <= '0;
         end else if (wr_en) begin
            pkt_len <= pkt_len + PW'(1);
         end

         // A dropped frame gives back every beat it had written.
         count <= count + PW'(wr_en) - PW'(m_hs) -
                  (drop_now ? pkt_len : '0);

         drop_q <= drop_now;
         if (drop_now && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Two-stage read: RAM read register, then the output register.
   assign readable = (PACKET_MODE != 0) ? (rd_ptr != commit_ptr)
                                        : (rd_ptr != wr_ptr);
   assign out_load = ram_vld && (!out_vld || m_axis_tready);
   assign rd_en    = readable && (!ram_vld || out_load);

   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_ptr  <= '0;
         ram_vld <= 1'b0;
         out_vld <= 1'b0;
         out_q   <= '0;
      end else begin
         rd_ptr  <= rd_ptr + PW'(rd_en);
         ram_vld <= rd_en || (ram_vld && !out_load);
         if (out_load) begin
            out_vld <= 1'b1;
            out_q   <= ram_q;
         end else if (m_axis_tready) begin
            out_vld <= 1'b0;
         end
      end
   end

   axis_fifo_ram #(
      .WIDTH (WW),
      .DEPTH (DEPTH)
   ) u_ram (
      .aclk    (aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (s_word),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (ram_q)
   );

   assign m_axis_tvalid = out_vld;
   assign {m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tlast,
           m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = out_q;

   assign status_count    = count;
   assign status_drop     = drop_q;
   assign status_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: instance 0 cut-through, instance 1 packet mode.
// Scoreboard queues hold expected beats; a monitor pops them on output.
module tb_axis_packet_fifo;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
      logic        id;
      logic        dest;
      logic [3:0]  user;
   } beat_t;

   logic        aclk;
   logic        areset;
   logic        s_tvalid [2];
   logic        s_tready [2];
   logic [31:0] s_tdata  [2];
   logic [3:0]  s_tstrb  [2];
   logic [3:0]  s_tkeep  [2];
   logic        s_tlast  [2];
   logic [0:0]  s_tid    [2];
   logic [0:0]  s_tdest  [2];
   logic [3:0]  s_tuser  [2];
   logic        m_tvalid [2];
   logic        m_tready [2];
   logic [31:0] m_tdata  [2];
   logic [3:0]  m_tstrb  [2];
   logic [3:0]  m_tkeep  [2];
   logic        m_tlast  [2];
   logic [0:0]  m_tid    [2];
   logic [0:0]  m_tdest  [2];
   logic [3:0]  m_tuser  [2];
   logic [4:0]  cnt      [2];
   logic        drop     [2];
   logic [15:0] dcnt     [2];

   int checks = 0;
   int errors = 0;
   beat_t q0[$];
   beat_t q1[$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axis_packet_fifo #(
         .TDATA_WIDTH          (4),
         .TID_WIDTH            (1),
         .TDEST_WIDTH          (1),
         .TUSER_WIDTH_PER_BYTE (1),
         .DEPTH                (16),
         .PACKET_MODE          (g)
      ) u_dut (
         .aclk            (aclk),
         .areset          (areset),
         .s_axis_tvalid   (s_tvalid[g]),
         .s_axis_tready   (s_tready[g]),
         .s_axis_tdata    (s_tdata[g]),
         .s_axis_tstrb    (s_tstrb[g]),
         .s_axis_tkeep    (s_tkeep[g]),
         .s_axis_tlast    (s_tlast[g]),
         .s_axis_tid      (s_tid[g]),
         .s_axis_tdest    (s_tdest[g]),
         .s_axis_tuser    (s_tuser[g]),
         .m_axis_tvalid   (m_tvalid[g]),
         .m_axis_tready   (m_tready[g]),
         .m_axis_tdata    (m_tdata[g]),
         .m_axis_tstrb    (m_tstrb[g]),
         .m_axis_tkeep    (m_tkeep[g]),
         .m_axis_tlast    (m_tlast[g]),
         .m_axis_tid      (m_tid[g]),
         .m_axis_tdest    (m_tdest[g]),
         .m_axis_tuser    (m_tuser[g]),
         .status_count    (cnt[g]),
         .status_drop     (drop[g]),
         .status_drop_cnt (dcnt[g])
      );
   end

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.strb = d[3:0];
      b.keep = 4'hF;
      b.last = l;
      b.id   = d[0];
      b.dest = d[1];
      b.user = d[7:4];
      return b;
   endfunction

   function automatic int qsize(input int m);
      return (m == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push(input int m, input beat_t b);
      if (m == 0) q0.push_back(b);
      else q1.push_back(b);
   endtask

   task automatic drive(input int m, input beat_t b);
      s_tvalid[m] = 1'b1;
      s_tdata[m]  = b.data;
      s_tstrb[m]  = b.strb;
      s_tkeep[m]  = b.keep;
      s_tlast[m]  = b.last;
      s_tid[m]    = b.id;
      s_tdest[m]  = b.dest;
      s_tuser[m]  = b.user;
   endtask

   task automatic idle(input int m);
      s_tvalid[m] = 1'b0;
      s_tlast[m]  = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int m, input beat_t b, input bit exp_out);
      int t;
      drive(m, b);
      t = 0;
      while (!s_tready[m] && t < 200) begin
         @(negedge aclk);
         t++;
      end
      chk("send_timeout", 64'(t < 200), 64'(1));
      if (exp_out) push(m, b);
      @(negedge aclk);
   endtask

   task automatic drain(input int m);
      int t;
      t = 0;
      while (qsize(m) != 0 && t < 200) begin
         @(negedge aclk);
         t++;
      end
      chk("drain_timeout", 64'(t < 200), 64'(1));
      repeat (2) @(negedge aclk);
      chk("drain_count", 64'(cnt[m]), 64'(0));
      chk("drain_tvalid", 64'(m_tvalid[m]), 64'(0));
   endtask

   task automatic cmp_out(input int g);
      beat_t e;
      int n;
      n = qsize(g);
      chk("out_expected", 64'(n != 0), 64'(1));
      if (n != 0) begin
         e = (g == 0) ? q0.pop_front() : q1.pop_front();
         chk("out_data", 64'(m_tdata[g]), 64'(e.data));
         chk("out_strb", 64'(m_tstrb[g]), 64'(e.strb));
         chk("out_keep", 64'(m_tkeep[g]), 64'(e.keep));
         chk("out_last", 64'(m_tlast[g]), 64'(e.last));
         chk("out_id", 64'(m_tid[g]), 64'(e.id));
         chk("out_dest", 64'(m_tdest[g]), 64'(e.dest));
         chk("out_user", 64'(m_tuser[g]), 64'(e.user));
      end
   endtask

   always begin
      @(negedge aclk);
      #1;
      for (int g = 0; g < 2; g++) begin
         if (!areset && m_tvalid[g] && m_tready[g]) cmp_out(g);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      for (int m = 0; m < 2; m++) begin
         idle(m);
         drive(m, mk(32'h0, 1'b0));
         s_tvalid[m] = 1'b0;
         m_tready[m] = 1'b0;
      end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      for (int m = 0; m < 2; m++) begin
         chk("rst_tvalid", 64'(m_tvalid[m]), 64'(0));
         chk("rst_tlast", 64'(m_tlast[m]), 64'(0));
         chk("rst_tready", 64'(s_tready[m]), 64'(1));
         chk("rst_count", 64'(cnt[m]), 64'(0));
         chk("rst_drop", 64'(drop[m]), 64'(0));
         chk("rst_dcnt", 64'(dcnt[m]), 64'(0));
      end

      // Single beat latency, cut-through.
      m_tready[0] = 1'b1;
      send(0, mk(32'hA5A50001, 1'b1), 1'b1);
      idle(0);
      chk("lat_cnt_e0", 64'(cnt[0]), 64'(1));
      chk("lat_vld_e0", 64'(m_tvalid[0]), 64'(0));
      @(negedge aclk);
      chk("lat_vld_e1", 64'(m_tvalid[0]), 64'(0));
      chk("lat_cnt_e1", 64'(cnt[0]), 64'(1));
      @(negedge aclk);
      chk("lat_vld_e2", 64'(m_tvalid[0]), 64'(1));
      @(negedge aclk);
      chk("lat_cnt_e3", 64'(cnt[0]), 64'(0));
      drain(0);

      // Fill to DEPTH under backpressure.
      m_tready[0] = 1'b0;
      for (int i = 0; i < 16; i++) send(0, mk(32'(i), 1'b0), 1'b1);
      drive(0, mk(32'd16, 1'b0));
      repeat (2) @(negedge aclk);
      chk("full_tready", 64'(s_tready[0]), 64'(0));
      chk("full_count", 64'(cnt[0]), 64'(16));
      chk("full_hold_vld", 64'(m_tvalid[0]), 64'(1));
      chk("full_hold_data", 64'(m_tdata[0]), 64'(0));
      m_tready[0] = 1'b1;
      chk("full_no_pass", 64'(s_tready[0]), 64'(0));
      for (int i = 16; i < 20; i++) send(0, mk(32'(i), i == 19), 1'b1);
      idle(0);
      drain(0);

      // Steady state at 8 beats held.
      m_tready[0] = 1'b0;
      for (int i = 0; i < 8; i++) send(0, mk(32'(100 + i), 1'b0), 1'b1);
      idle(0);
      repeat (3) @(negedge aclk);
      chk("steady_pre", 64'(cnt[0]), 64'(8));
      m_tready[0] = 1'b1;
      for (int i = 0; i < 32; i++) begin
         send(0, mk(32'(200 + i), i == 31), 1'b1);
         chk("steady_cnt", 64'(cnt[0]), 64'(8));
      end
      idle(0);
      drain(0);

      // Packet mode: no release before tlast.
      m_tready[1] = 1'b1;
      for (int i = 0; i < 3; i++) send(1, mk(32'h10 + 32'(i), 1'b0), 1'b1);
      idle(1);
      for (int i = 0; i < 4; i++) begin
         chk("pkt_hold", 64'(m_tvalid[1]), 64'(0));
         @(negedge aclk);
      end
      send(1, mk(32'h13, 1'b1), 1'b1);
      idle(1);
      chk("pkt_lat_e0", 64'(m_tvalid[1]), 64'(0));
      @(negedge aclk);
      chk("pkt_lat_e1", 64'(m_tvalid[1]), 64'(0));
      @(negedge aclk);
      chk("pkt_lat_e2", 64'(m_tvalid[1]), 64'(1));
      drain(1);

      // Oversize frame dropped, following frame passes.
      for (int i = 0; i < 20; i++) begin
         send(1, mk(32'h200 + 32'(i), i == 19), 1'b0);
         chk("ovs_drop", 64'(drop[1]), 64'(i == 16));
         chk("ovs_tready", 64'(s_tready[1]), 64'(1));
         if (i == 16) chk("ovs_cnt", 64'(cnt[1]), 64'(0));
      end
      send(1, mk(32'hB0, 1'b0), 1'b1);
      chk("ovs_drop_after", 64'(drop[1]), 64'(0));
      send(1, mk(32'hB1, 1'b1), 1'b1);
      idle(1);
      chk("ovs_dcnt", 64'(dcnt[1]), 64'(1));
      drain(1);

      // Exactly DEPTH beats fits.
      m_tready[1] = 1'b0;
      for (int i = 0; i < 16; i++) send(1, mk(32'h300 + 32'(i), i == 15), 1'b1);
      idle(1);
      chk("fit_count", 64'(cnt[1]), 64'(16));
      chk("fit_drop", 64'(drop[1]), 64'(0));
      m_tready[1] = 1'b1;
      drain(1);
      chk("fit_dcnt", 64'(dcnt[1]), 64'(1));
      chk("norm_dcnt", 64'(dcnt[0]), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
